// File: rtl/rc_pkg.sv
// Shared drive-controller types: FSM state encoding and per-state H-bridge leg patterns.
// Leg vectors are ordered {lmot_a, lmot_b, rmot_a, rmot_b}.
package rc_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FWD    = 3'd1,
    REV    = 3'd2,
    HAZ    = 3'd3,
    TURN_L = 3'd4,
    TURN_R = 3'd5,
    DEAD   = 3'd6
  } state_e;

  localparam logic [3:0] LEGS_OFF    = 4'b0000;
  localparam logic [3:0] LEGS_FWD    = 4'b1001;
  localparam logic [3:0] LEGS_REV    = 4'b0110;
  localparam logic [3:0] LEGS_TURN_L = 4'b1000;
  localparam logic [3:0] LEGS_TURN_R = 4'b0001;

  function automatic logic [3:0] legs_of(input state_e s);
    case (s)
      FWD:     return LEGS_FWD;
      REV:     return LEGS_REV;
      TURN_L:  return LEGS_TURN_L;
      TURN_R:  return LEGS_TURN_R;
      default: return LEGS_OFF;
    endcase
  endfunction

  function automatic logic is_motion(input state_e s);
    return s inside {FWD, REV, TURN_L, TURN_R};
  endfunction

endpackage

// File: rtl/rc_drive_ctrl_if.sv
// Button/speed inputs and motor/lamp outputs of the drive controller.
// The controller sits on the slave side; the board (or bench) is the master.
interface rc_drive_ctrl_if #(
  parameter int PWM_W = 8
);
  logic             btn_up;
  logic             btn_down;
  logic             btn_left;
  logic             btn_right;
  logic [PWM_W-1:0] speed;
  logic             lmot_a;
  logic             lmot_b;
  logic             rmot_a;
  logic             rmot_b;
  logic             left_ind;
  logic             right_ind;
  logic             brake_l;
  logic             brake_r;

  modport master (
    output btn_up, btn_down, btn_left, btn_right, speed,
    input  lmot_a, lmot_b, rmot_a, rmot_b, left_ind, right_ind, brake_l, brake_r
  );

  modport slave (
    input  btn_up, btn_down, btn_left, btn_right, speed,
    output lmot_a, lmot_b, rmot_a, rmot_b, left_ind, right_ind, brake_l, brake_r
  );
endinterface

// File: rtl/rc_btn_debounce.sv
// Two-flop synchroniser followed by a stable-time debouncer for one raw button.
// Output follows the synchronised input once it has differed for DEBOUNCE consecutive cycles.
module rc_btn_debounce #(
  parameter int DEBOUNCE = 500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic btn_o
);
  localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          deb_q, deb_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Any cycle where the synchronised value agrees with the output restarts the count.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (cnt_q == CNT_LAST) begin
        deb_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign btn_o = deb_q;
endmodule

// File: rtl/rc_drive_ctrl.sv
// RC car drive controller: debounced, prioritised buttons drive an FSM with H-bridge dead-time,
// PWM speed control and blinking indicators. All outputs are registered alongside the state.
module rc_drive_ctrl
  import rc_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BLINK_HALF = CLK_HZ / 2,
  parameter int DEBOUNCE   = CLK_HZ / 100,
  parameter int DEADTIME   = CLK_HZ / 1000,
  parameter int PWM_W      = 8
) (
  input logic            clk,
  input logic            rst_n,
  rc_drive_ctrl_if.slave bus
);
  localparam int BW = $clog2(BLINK_HALF);
  localparam int DW = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);
  localparam logic [DW-1:0] DEAD_LAST  = DW'(DEADTIME - 1);

  logic up_db, down_db, left_db, right_db;

  rc_btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_up    (.clk(clk), .rst_n(rst_n), .btn_i(bus.btn_up),    .btn_o(up_db));
  rc_btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_down  (.clk(clk), .rst_n(rst_n), .btn_i(bus.btn_down),  .btn_o(down_db));
  rc_btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_left  (.clk(clk), .rst_n(rst_n), .btn_i(bus.btn_left),  .btn_o(left_db));
  rc_btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_right (.clk(clk), .rst_n(rst_n), .btn_i(bus.btn_right), .btn_o(right_db));

  state_e           state_q, state_d, target;
  logic [DW-1:0]    dead_q, dead_d;
  logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [PWM_W-1:0] spd_q, spd_d;
  logic             pwm_on_d;
  logic [BW-1:0]    blink_cnt_q, blink_cnt_d;
  logic             blink_q, blink_d;
  logic [3:0]       legs_q, legs_d;
  logic             lind_q, lind_d;
  logic             rind_q, rind_d;
  logic             brake_q, brake_d;

  always_comb begin
    target = IDLE;
    if (up_db)                     target = FWD;
    else if (down_db)              target = REV;
    else if (left_db && right_db)  target = HAZ;
    else if (left_db)              target = TURN_L;
    else if (right_db)             target = TURN_R;
  end

  always_comb begin
    state_d = state_q;
    dead_d  = '0;
    case (state_q)
      IDLE, HAZ: state_d = target;
      DEAD: begin
        if (dead_q == DEAD_LAST) state_d = target;
        else                     dead_d  = dead_q + 1'b1;
      end
      default: if (target != state_q) state_d = DEAD;
    endcase

    // Speed is captured as the counter wraps so every period runs at one duty.
    pwm_cnt_d = pwm_cnt_q + 1'b1;
    spd_d     = (pwm_cnt_d == '0) ? bus.speed : spd_q;
    pwm_on_d  = (pwm_cnt_d < spd_d) | (&spd_d);

    blink_cnt_d = '0;
    blink_d     = 1'b0;
    if (state_d inside {TURN_L, TURN_R, HAZ}) begin
      if (state_d != state_q) begin
        blink_d = 1'b1;
      end else if (blink_cnt_q == BLINK_LAST) begin
        blink_d = ~blink_q;
      end else begin
        blink_d     = blink_q;
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end

    legs_d  = legs_of(state_d) & {4{pwm_on_d}};
    lind_d  = blink_d & (state_d inside {TURN_L, HAZ});
    rind_d  = blink_d & (state_d inside {TURN_R, HAZ});
    brake_d = ~is_motion(state_d);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dead_q      <= '0;
      pwm_cnt_q   <= '0;
      spd_q       <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      legs_q      <= LEGS_OFF;
      lind_q      <= 1'b0;
      rind_q      <= 1'b0;
      brake_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      dead_q      <= dead_d;
      pwm_cnt_q   <= pwm_cnt_d;
      spd_q       <= spd_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      legs_q      <= legs_d;
      lind_q      <= lind_d;
      rind_q      <= rind_d;
      brake_q     <= brake_d;
    end
  end

  assign bus.lmot_a    = legs_q[3];
  assign bus.lmot_b    = legs_q[2];
  assign bus.rmot_a    = legs_q[1];
  assign bus.rmot_b    = legs_q[0];
  assign bus.left_ind  = lind_q;
  assign bus.right_ind = rind_q;
  assign bus.brake_l   = brake_q;
  assign bus.brake_r   = brake_q;
endmodule
